// File: rtl/soc_bram_memtest.sv
// rtl/soc_bram_memtest.sv - two-pass BRAM pattern tester (P(a), then ~P(a)) with first-fail capture
module soc_bram_memtest #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [31:0]   seed,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [AW-1:0] fail_addr,
  output logic [31:0]   fail_exp,
  output logic [31:0]   fail_got,
  output logic [15:0]   err_cnt,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wmsk,
  output logic          mem_we
);

  typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, CHK} state_t;

  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   seed_q, seed_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic [AW-1:0] fail_addr_q, fail_addr_d;
  logic [31:0]   fail_exp_q, fail_exp_d;
  logic [31:0]   fail_got_q, fail_got_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic          cmp_vld_q, cmp_vld_d;
  logic [AW-1:0] cmp_addr_q, cmp_addr_d;
  logic [31:0]   cmp_exp_q, cmp_exp_d;

  logic          last_addr;
  logic          start_ok;
  logic          in_pass;
  logic          in_rd;
  logic [31:0]   pat_word;

  assign last_addr = &addr_q;
  assign start_ok  = (state_q == IDLE) && start;
  assign in_pass   = (state_q == WR0) || (state_q == RD0) || (state_q == WR1) || (state_q == RD1);
  assign in_rd     = (state_q == RD0) || (state_q == RD1);
  // Second write/read pass uses the inverted pattern so every bit is exercised both ways.
  assign pat_word  = ((state_q == WR1) || (state_q == RD1)) ?
                     ~(seed_q ^ {{(32-AW){1'b0}}, addr_q}) :
                      (seed_q ^ {{(32-AW){1'b0}}, addr_q});

  // State register; reset drops straight to IDLE so mem_we falls without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Pass sequencing: each pass walks the full address space once, CHK drains the last compare.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = WR0;
      WR0:     if (last_addr) state_d = RD0;
      RD0:     if (last_addr) state_d = WR1;
      WR1:     if (last_addr) state_d = RD1;
      RD1:     if (last_addr) state_d = CHK;
      CHK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side and status outputs decoded from the current state.
  always_comb begin
    busy      = (state_q != IDLE);
    mem_we    = (state_q == WR0) || (state_q == WR1);
    mem_addr  = in_pass ? addr_q : '0;
    mem_wdata = mem_we ? pat_word : 32'h0;
    mem_wmsk  = 4'b0000;
    done      = done_q;
    fail      = fail_q;
    fail_addr = fail_addr_q;
    fail_exp  = fail_exp_q;
    fail_got  = fail_got_q;
    err_cnt   = err_cnt_q;
  end

  // Address walk, one-stage compare pipeline, and sticky result capture.
  always_comb begin
    addr_d      = '0;
    seed_d      = seed_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_exp_d  = fail_exp_q;
    fail_got_d  = fail_got_q;
    err_cnt_d   = err_cnt_q;
    cmp_vld_d   = in_rd;
    cmp_addr_d  = addr_q;
    cmp_exp_d   = pat_word;

    if (in_pass) addr_d = addr_q + ADDR_ONE;

    if (start_ok) begin
      seed_d      = seed;
      done_d      = 1'b0;
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_exp_d  = 32'h0;
      fail_got_d  = 32'h0;
      err_cnt_d   = 16'h0;
    end else if (cmp_vld_q && (mem_rdata != cmp_exp_q)) begin
      fail_d = 1'b1;
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      if (!fail_q) begin
        fail_addr_d = cmp_addr_q;
        fail_exp_d  = cmp_exp_q;
        fail_got_d  = mem_rdata;
      end
    end

    if (state_q == CHK) done_d = 1'b1;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      seed_q      <= 32'h0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_exp_q  <= 32'h0;
      fail_got_q  <= 32'h0;
      err_cnt_q   <= 16'h0;
      cmp_vld_q   <= 1'b0;
      cmp_addr_q  <= '0;
      cmp_exp_q   <= 32'h0;
    end else begin
      addr_q      <= addr_d;
      seed_q      <= seed_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_exp_q  <= fail_exp_d;
      fail_got_q  <= fail_got_d;
      err_cnt_q   <= err_cnt_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_exp_q   <= cmp_exp_d;
    end
  end

endmodule
